// File: rtl/prn_corr_pkg.sv
// Shared types and helpers for the PRN early/prompt/late correlator.
// Optional build macro CORR_SAT_EN selects saturating accumulation.
package prn_corr_pkg;

    localparam int unsigned SAMP_WIDTH_DEF = 4;
    localparam int unsigned ACC_WIDTH_DEF  = 24;
    localparam int unsigned EL_SPACING_DEF = 2;

    typedef enum logic {
        WAIT_SOP = 1'b0,
        ACCUM    = 1'b1
    } corr_state_t;

    // Local code chip 0 maps to +1, chip 1 maps to -1.
    function automatic logic chip_is_neg(input logic chip);
        return chip;
    endfunction

    // Symmetric clamp limits; the most negative code is excluded so a clamped value negates safely.
    function automatic longint sat_max(input int unsigned w);
        return (longint'(1) << (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int unsigned w);
        return -sat_max(w);
    endfunction

endpackage

// File: rtl/prn_corr_acc_lane.sv
// One integrate-and-dump lane: code-signed sample contribution, accumulator and dump sum.
// With CORR_SAT_EN defined the add clamps to the symmetric limits, otherwise it wraps.
module prn_corr_acc_lane
    import prn_corr_pkg::*;
#(
    parameter int unsigned SAMP_WIDTH = SAMP_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                         rx_clk,
    input  logic                         rx_rst,
    input  logic                         clr,
    input  logic                         load,
    input  logic                         samp_vld,
    input  logic signed [SAMP_WIDTH-1:0] samp,
    input  logic                         code,
    output logic signed [ACC_WIDTH-1:0]  sum_c
);

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] ext;
    logic signed [ACC_WIDTH-1:0] contrib;

    assign ext     = ACC_WIDTH'(samp);
    assign contrib = !samp_vld        ? '0 :
                     chip_is_neg(code) ? -ext : ext;

`ifdef CORR_SAT_EN
    localparam logic signed [ACC_WIDTH:0] SUM_MAX = (ACC_WIDTH + 1)'(sat_max(ACC_WIDTH));
    localparam logic signed [ACC_WIDTH:0] SUM_MIN = (ACC_WIDTH + 1)'(sat_min(ACC_WIDTH));

    logic signed [ACC_WIDTH:0] wide_sum;

    // One guard bit is enough to detect overflow of a single add.
    always_comb begin
        wide_sum = (ACC_WIDTH + 1)'(acc) + (ACC_WIDTH + 1)'(contrib);
        if (wide_sum > SUM_MAX) begin
            sum_c = ACC_WIDTH'(SUM_MAX);
        end else if (wide_sum < SUM_MIN) begin
            sum_c = ACC_WIDTH'(SUM_MIN);
        end else begin
            sum_c = ACC_WIDTH'(wide_sum);
        end
    end
`else
    assign sum_c = acc + contrib;
`endif

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (load) begin
            acc <= contrib;
        end else begin
            acc <= sum_c;
        end
    end

endmodule

// File: rtl/prn_corr_accum.sv
// Early/prompt/late I/Q integrate-and-dump correlator, one result per code epoch,
// delivered through a valid/ready holding register. Build macro: CORR_SAT_EN.
module prn_corr_accum
    import prn_corr_pkg::*;
#(
    parameter int unsigned SAMP_WIDTH = SAMP_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int unsigned EL_SPACING = EL_SPACING_DEF
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst,
    input  logic                  rx_trk_en,
    input  logic                  rx_samp_vld,
    input  logic [SAMP_WIDTH-1:0] rx_samp_i,
    input  logic [SAMP_WIDTH-1:0] rx_samp_q,
    input  logic                  rx_loc_code,
    input  logic                  rx_prn_sop,
    input  logic                  rx_prn_eop,
    input  logic                  rx_corr_rdy,
    output logic                  tx_corr_vld,
    output logic [ACC_WIDTH-1:0]  tx_ie,
    output logic [ACC_WIDTH-1:0]  tx_qe,
    output logic [ACC_WIDTH-1:0]  tx_ip,
    output logic [ACC_WIDTH-1:0]  tx_qp,
    output logic [ACC_WIDTH-1:0]  tx_il,
    output logic [ACC_WIDTH-1:0]  tx_ql,
    output logic [7:0]            tx_epoch_cnt,
    output logic                  tx_corr_ovf
);

    localparam int unsigned DLY_LEN = 2 * EL_SPACING;
    localparam int unsigned N_LANES = 6;

    corr_state_t                 state;
    logic [DLY_LEN-1:0]          dly;
    logic [7:0]                  epoch_cnt;
    logic [2:0]                  tap_c;
    logic                        lane_clr_c;
    logic                        lane_load_c;
    logic                        dump_c;
    logic signed [ACC_WIDTH-1:0] sum_c [N_LANES];

    // Tap order: [0] early, [1] prompt, [2] late.
    assign tap_c = {dly[DLY_LEN-1], dly[EL_SPACING-1], rx_loc_code};

    // Lane control; eop wins over a coincident sop, enable drop wins over both.
    always_comb begin
        lane_clr_c  = 1'b0;
        lane_load_c = 1'b0;
        dump_c      = 1'b0;
        if (!rx_trk_en) begin
            lane_clr_c = 1'b1;
        end else if (state == WAIT_SOP) begin
            if (rx_prn_sop) begin
                lane_load_c = 1'b1;
            end else begin
                lane_clr_c = 1'b1;
            end
        end else if (rx_prn_eop) begin
            dump_c     = 1'b1;
            lane_clr_c = 1'b1;
        end else if (rx_prn_sop) begin
            lane_load_c = 1'b1;
        end
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state <= WAIT_SOP;
        end else if (!rx_trk_en) begin
            state <= WAIT_SOP;
        end else if (state == WAIT_SOP && rx_prn_sop) begin
            state <= ACCUM;
        end
    end

    // Code delay line advances only with valid samples so spacing is in samples, not cycles.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            dly <= '0;
        end else if (rx_samp_vld) begin
            dly <= {dly[DLY_LEN-2:0], rx_loc_code};
        end
    end

    // Lane index = 2*tap + (0 for I, 1 for Q): IE, QE, IP, QP, IL, QL.
    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        prn_corr_acc_lane #(
            .SAMP_WIDTH (SAMP_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .rx_clk   (rx_clk),
            .rx_rst   (rx_rst),
            .clr      (lane_clr_c),
            .load     (lane_load_c),
            .samp_vld (rx_samp_vld),
            .samp     ((g % 2 == 0) ? rx_samp_i : rx_samp_q),
            .code     (tap_c[g / 2]),
            .sum_c    (sum_c[g])
        );
    end

    // Result holding register; a dump against a stalled result is dropped and flagged.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            tx_corr_vld  <= 1'b0;
            tx_ie        <= '0;
            tx_qe        <= '0;
            tx_ip        <= '0;
            tx_qp        <= '0;
            tx_il        <= '0;
            tx_ql        <= '0;
            tx_epoch_cnt <= '0;
            tx_corr_ovf  <= 1'b0;
            epoch_cnt    <= '0;
        end else if (dump_c) begin
            epoch_cnt <= epoch_cnt + 8'd1;
            if (!tx_corr_vld || rx_corr_rdy) begin
                tx_corr_vld  <= 1'b1;
                tx_ie        <= sum_c[0];
                tx_qe        <= sum_c[1];
                tx_ip        <= sum_c[2];
                tx_qp        <= sum_c[3];
                tx_il        <= sum_c[4];
                tx_ql        <= sum_c[5];
                tx_epoch_cnt <= epoch_cnt;
            end else begin
                tx_corr_ovf <= 1'b1;
            end
        end else if (rx_corr_rdy) begin
            tx_corr_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prn_corr_accum.sv
// Self-checking bench for prn_corr_accum: table of epochs with a result scoreboard,
// plus hand sequences for reset, backpressure, restart, enable drop and overflow.
module tb_prn_corr_accum;
    import prn_corr_pkg::*;

    localparam int unsigned SW     = 4;
    localparam int unsigned AW     = 24;
    localparam int unsigned EL     = 2;
    localparam int unsigned AW_OVF = 8;
`ifdef CORR_SAT_EN
    localparam int EXP_OVF = 127;
`else
    localparam int EXP_OVF = 24;
`endif

    logic          rx_clk = 1'b0;
    logic          rx_rst = 1'b1;
    logic          rx_trk_en = 1'b1;
    logic          rx_samp_vld = 1'b0;
    logic [SW-1:0] rx_samp_i = '0;
    logic [SW-1:0] rx_samp_q = '0;
    logic          rx_loc_code = 1'b0;
    logic          rx_prn_sop = 1'b0;
    logic          rx_prn_eop = 1'b0;
    logic          rx_corr_rdy = 1'b1;

    logic          tx_corr_vld, tx_corr_ovf;
    logic [AW-1:0] tx_ie, tx_qe, tx_ip, tx_qp, tx_il, tx_ql;
    logic [7:0]    tx_epoch_cnt;

    logic              o_vld, o_ovf;
    logic [AW_OVF-1:0] o_ie, o_qe, o_ip, o_qp, o_il, o_ql;
    logic [7:0]        o_cnt;

    always #5 rx_clk = ~rx_clk;

    prn_corr_accum #(.SAMP_WIDTH(SW), .ACC_WIDTH(AW), .EL_SPACING(EL)) u_dut (
        .rx_clk(rx_clk), .rx_rst(rx_rst), .rx_trk_en(rx_trk_en), .rx_samp_vld(rx_samp_vld),
        .rx_samp_i(rx_samp_i), .rx_samp_q(rx_samp_q), .rx_loc_code(rx_loc_code),
        .rx_prn_sop(rx_prn_sop), .rx_prn_eop(rx_prn_eop), .rx_corr_rdy(rx_corr_rdy),
        .tx_corr_vld(tx_corr_vld), .tx_ie(tx_ie), .tx_qe(tx_qe), .tx_ip(tx_ip), .tx_qp(tx_qp),
        .tx_il(tx_il), .tx_ql(tx_ql), .tx_epoch_cnt(tx_epoch_cnt), .tx_corr_ovf(tx_corr_ovf)
    );

    // Narrow-accumulator instance for the wrap/clamp case.
    prn_corr_accum #(.SAMP_WIDTH(SW), .ACC_WIDTH(AW_OVF), .EL_SPACING(EL)) u_ovf (
        .rx_clk(rx_clk), .rx_rst(rx_rst), .rx_trk_en(rx_trk_en), .rx_samp_vld(rx_samp_vld),
        .rx_samp_i(rx_samp_i), .rx_samp_q(rx_samp_q), .rx_loc_code(rx_loc_code),
        .rx_prn_sop(rx_prn_sop), .rx_prn_eop(rx_prn_eop), .rx_corr_rdy(rx_corr_rdy),
        .tx_corr_vld(o_vld), .tx_ie(o_ie), .tx_qe(o_qe), .tx_ip(o_ip), .tx_qp(o_qp),
        .tx_il(o_il), .tx_ql(o_ql), .tx_epoch_cnt(o_cnt), .tx_corr_ovf(o_ovf)
    );

    typedef struct {
        logic signed [SW-1:0] i;
        logic signed [SW-1:0] q;
        int                   len;
        int                   chip_pos;
        bit                   gaps;
        int                   e_ie, e_qe, e_ip, e_qp, e_il, e_ql;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] ie, qe, ip, qp, il, ql;
        logic [7:0]    cnt;
    } res_t;

    res_t exp_q[$];
    res_t mon_got, mon_want;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;
    vec_t vecs[7];

    function automatic vec_t mk(input int i, input int q, input int len, input int pos, input bit gaps,
                                input int ie, input int qe, input int ip, input int qp,
                                input int il, input int ql);
        vec_t v;
        v.i = SW'(i); v.q = SW'(q); v.len = len; v.chip_pos = pos; v.gaps = gaps;
        v.e_ie = ie; v.e_qe = qe; v.e_ip = ip; v.e_qp = qp; v.e_il = il; v.e_ql = ql;
        return v;
    endfunction

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic drive(input logic vld, input logic sop, input logic eop, input logic code,
                         input logic signed [SW-1:0] si, input logic signed [SW-1:0] sq);
        @(posedge rx_clk);
        #1;
        rx_samp_vld = vld; rx_prn_sop = sop; rx_prn_eop = eop;
        rx_loc_code = code; rx_samp_i = si; rx_samp_q = sq;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Drives one sop..eop epoch; push=0 for a result the bench knows will be dropped.
    task automatic run_epoch(input vec_t v, input bit push, input bit rdy_at_eop);
        res_t r;
        for (int k = 0; k < v.len; k++) begin
            drive(1'b1, k == 0, k == v.len - 1, k == v.chip_pos, v.i, v.q);
            if (rdy_at_eop && k == v.len - 1) rx_corr_rdy = 1'b1;
            if (v.gaps && k != v.len - 1) drive(1'b0, 1'b0, 1'b0, 1'b1, -4'sd8, -4'sd8);
        end
        r = {AW'(v.e_ie), AW'(v.e_qe), AW'(v.e_ip), AW'(v.e_qp), AW'(v.e_il), AW'(v.e_ql), 8'(exp_cnt)};
        if (push) exp_q.push_back(r);
        exp_cnt = (exp_cnt + 1) % 256;
    endtask

    task automatic do_reset();
        rx_rst = 1'b1;
        exp_q.delete();
        exp_cnt = 0;
        idle(2);
        rx_rst = 1'b0;
    endtask

    // Scoreboard: a result is consumed on every edge that sees vld & rdy.
    always @(negedge rx_clk) begin
        if (!rx_rst && tx_corr_vld && rx_corr_rdy) begin
            mon_got = {tx_ie, tx_qe, tx_ip, tx_qp, tx_il, tx_ql, tx_epoch_cnt};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got ip=%0d cnt=%0d, required no result",
                         $signed(mon_got.ip), mon_got.cnt);
            end else begin
                mon_want = exp_q.pop_front();
                if (mon_got !== mon_want) begin
                    n_fail++;
                    $display("FAIL result_cnt%0d: got e=%0d/%0d p=%0d/%0d l=%0d/%0d cnt=%0d, required e=%0d/%0d p=%0d/%0d l=%0d/%0d cnt=%0d",
                             mon_want.cnt,
                             $signed(mon_got.ie), $signed(mon_got.qe), $signed(mon_got.ip),
                             $signed(mon_got.qp), $signed(mon_got.il), $signed(mon_got.ql), mon_got.cnt,
                             $signed(mon_want.ie), $signed(mon_want.qe), $signed(mon_want.ip),
                             $signed(mon_want.qp), $signed(mon_want.il), $signed(mon_want.ql), mon_want.cnt);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = mk( 3,  0, 4092,  -1, 1'b0, 12276,   0, 12276,   0, 12276,   0);
        vecs[1] = mk( 1,  0, 4092, 100, 1'b0,  4090,   0,  4090,   0,  4090,   0);
        vecs[2] = mk(-2,  5,   20,  18, 1'b0,   -36,  90,   -40, 100,   -40, 100);
        vecs[3] = mk( 4, -1,   10,  -1, 1'b0,    40, -10,    32,  -8,    32,  -8);
        vecs[4] = mk(-8, -8,   16,   0, 1'b1,  -112,-112,  -112,-112,  -112,-112);
        vecs[5] = mk( 5, -3,    1,   0, 1'b0,    -5,   3,     5,  -3,     5,  -3);
        vecs[6] = mk( 1,  1,    8,  -1, 1'b0,     8,   8,     6,   6,     6,   6);

        idle(2);
        check("reset_vld", 64'(tx_corr_vld), 0);
        check("reset_ip",  $signed(tx_ip), 0);
        check("reset_cnt", 64'(tx_epoch_cnt), 0);
        check("reset_ovf", 64'(tx_corr_ovf), 0);
        rx_rst = 1'b0;
        idle(2);

        for (int n = 0; n < 7; n++) begin
            run_epoch(vecs[n], 1'b1, 1'b0);
            idle(3);
        end

        // Reset in the middle of an epoch while a result is held.
        rx_corr_rdy = 1'b0;
        run_epoch(mk(1, 1, 5, -1, 1'b0, 5, 5, 5, 5, 5, 5), 1'b0, 1'b0);
        idle(2);
        check("hold_vld", 64'(tx_corr_vld), 1);
        for (int k = 0; k < 5; k++) drive(1'b1, k == 0, 1'b0, 1'b0, 4'sd2, 4'sd2);
        #2;
        rx_rst = 1'b1;
        #1;
        check("midrst_vld", 64'(tx_corr_vld), 0);
        check("midrst_ip",  $signed(tx_ip), 0);
        check("midrst_cnt", 64'(tx_epoch_cnt), 0);
        do_reset();
        rx_corr_rdy = 1'b1;
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, k == 4, 1'b0, 4'sd3, 4'sd3);
        idle(3);
        check("no_dump_without_sop", 64'(tx_corr_vld), 0);
        run_epoch(mk(2, -1, 6, -1, 1'b0, 12, -6, 12, -6, 12, -6), 1'b1, 1'b0);
        idle(3);

        // Dump landing on the same edge as a transfer of the held result.
        rx_corr_rdy = 1'b0;
        run_epoch(mk(1, 1, 4, -1, 1'b0, 4, 4, 4, 4, 4, 4), 1'b1, 1'b0);
        idle(3);
        check("stall_vld", 64'(tx_corr_vld), 1);
        check("stall_ip",  $signed(tx_ip), 4);
        run_epoch(mk(-1, 2, 6, -1, 1'b0, -6, 12, -6, 12, -6, 12), 1'b1, 1'b1);
        idle(3);
        check("concurrent_no_ovf", 64'(tx_corr_ovf), 0);
        check("concurrent_drained", 64'(tx_corr_vld), 0);

        // Backpressure across two epochs: second result dropped.
        do_reset();
        rx_corr_rdy = 1'b0;
        run_epoch(mk(3, -2, 8, -1, 1'b0, 24, -16, 24, -16, 24, -16), 1'b1, 1'b0);
        idle(2);
        run_epoch(mk(-3, 1, 8, -1, 1'b0, -24, 8, -24, 8, -24, 8), 1'b0, 1'b0);
        idle(3);
        check("bp_vld", 64'(tx_corr_vld), 1);
        check("bp_ip",  $signed(tx_ip), 24);
        check("bp_qp",  $signed(tx_qp), -16);
        check("bp_cnt", 64'(tx_epoch_cnt), 0);
        check("bp_ovf", 64'(tx_corr_ovf), 1);
        rx_corr_rdy = 1'b1;
        idle(3);
        run_epoch(mk(1, -1, 5, -1, 1'b0, 5, -5, 5, -5, 5, -5), 1'b1, 1'b0);
        idle(3);
        check("bp_ovf_sticky", 64'(tx_corr_ovf), 1);

        // Sop restart at sample 50: only samples 50..99 count.
        for (int k = 0; k < 100; k++)
            drive(1'b1, k == 0 || k == 50, k == 99, 1'b0, (k < 50) ? 4'sd7 : 4'sd1, -4'sd2);
        exp_q.push_back({AW'(50), AW'(-100), AW'(50), AW'(-100), AW'(50), AW'(-100), 8'(exp_cnt)});
        exp_cnt++;
        idle(3);

        // One-cycle enable drop aborts the epoch.
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, k == 0, k == 19, 1'b0, 4'sd1, 4'sd1);
            rx_trk_en = (k != 10);
        end
        idle(3);
        check("en_drop_no_vld", 64'(tx_corr_vld), 0);
        run_epoch(mk(2, 3, 7, -1, 1'b0, 14, 21, 14, 21, 14, 21), 1'b1, 1'b0);
        idle(3);

        // Narrow accumulator overflow: 40 x 7 = 280.
        run_epoch(mk(7, 0, 40, -1, 1'b0, 280, 0, 280, 0, 280, 0), 1'b1, 1'b0);
        idle(1);
        check("ovf_vld", 64'(o_vld), 1);
        check("ovf_ie",  $signed(o_ie), EXP_OVF);
        check("ovf_ip",  $signed(o_ip), EXP_OVF);
        check("ovf_il",  $signed(o_il), EXP_OVF);
        check("ovf_qp",  $signed(o_qp), 0);
        idle(3);

        for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(posedge rx_clk);
        check("scoreboard_drained", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prn_corr_accum.md
Name: prn_corr_accum

Overview:
- Consumer end of the local-code interface driven by the tracking PRN/TMBOC generator: takes the local code chip stream and its sop/eop epoch markers, together with baseband I/Q samples.
- Produces early/prompt/late integrate-and-dump correlations, one set per code epoch.
- Sits between the generator and the loop discriminator / software readout. Results leave through a valid/ready holding register.

Parameters:
- SAMP_WIDTH, 4, signed two's-complement width of rx_samp_i/rx_samp_q.
- ACC_WIDTH, 24, signed width of each accumulator and result.
- EL_SPACING, 2, early-prompt and prompt-late spacing in valid samples (>=1).

Ports:
- rx_clk  in  1  clock
- rx_rst  in  1  asynchronous reset, active-high
- rx_trk_en  in  1  tracking enable; low aborts accumulation
- rx_samp_vld  in  1  I/Q sample and code chip valid this cycle
- rx_samp_i  in  SAMP_WIDTH  signed in-phase sample
- rx_samp_q  in  SAMP_WIDTH  signed quadrature sample
- rx_loc_code  in  1  local code chip (0 = +1, 1 = -1)
- rx_prn_sop  in  1  first chip of code epoch
- rx_prn_eop  in  1  last chip of code epoch
- rx_corr_rdy  in  1  downstream accepts result
- tx_corr_vld  out  1  result register holds unread result
- tx_ie, tx_qe, tx_ip, tx_qp, tx_il, tx_ql  out  ACC_WIDTH each  E/P/L correlation results
- tx_epoch_cnt  out  8  epoch index of the held result
- tx_corr_ovf  out  1  sticky: a result was dropped

Behaviour:
- Reset (async, rx_rst=1): all outputs 0, accumulators 0, delay line 0, state WAIT_SOP. Epoch counter internal 0.
- Code taps:
  - Delay line of 2*EL_SPACING bits, shifted with rx_loc_code only when rx_samp_vld=1.
  - early = rx_loc_code (current); prompt = dly[EL_SPACING-1]; late = dly[2*EL_SPACING-1].
- Contribution: per lane, sample sign-extended to ACC_WIDTH and negated when the tap = 1. Added only when rx_samp_vld=1.
- FSM WAIT_SOP:
  - Accumulators held at 0.
  - rx_trk_en=1 & rx_prn_sop=1 -> ACCUM. That cycle's contribution is loaded as the initial accumulator value.
- FSM ACCUM:
  - Accumulate every valid sample.
  - rx_prn_sop without eop -> restart: accumulators := current contribution, no dump.
  - rx_prn_eop -> dump: result = accumulator + current contribution. Accumulators := 0 next cycle. Remain in ACCUM; the next sop starts the new epoch.
  - eop and sop in the same cycle: dump only; sop ignored.
- rx_trk_en=0 in any state -> WAIT_SOP next cycle, accumulators cleared. The result register is untouched.
- Dump path:
  - Latency 1 cycle: tx_corr_vld rises on the edge after the eop cycle.
  - tx_epoch_cnt takes the internal counter value, then the counter increments (255 wraps to 0).
- Handshake:
  - Result transfers on an edge with tx_corr_vld=1 & rx_corr_rdy=1; vld then falls unless a new dump loads the same edge.
  - Outputs are stable while vld=1 and rdy=0.
  - Dump while vld=1 & rdy=0: new result discarded, old kept, tx_corr_ovf set (sticky until rx_rst). Epoch counter still increments, so the gap is visible.
  - Dump with vld=1 & rdy=1: new result loaded, vld stays 1, no overflow.
- Arithmetic: two's complement wrap at ACC_WIDTH unless CORR_SAT_EN is defined.

Optional Feature:
- Macro: CORR_SAT_EN.
- Defined: each accumulator add saturates to [-(2^(ACC_WIDTH-1)-1), +(2^(ACC_WIDTH-1)-1)]. A saturated result is reported at the clamp value.
- Undefined: plain modular add, no clamp logic.

Decomposition:
- Package prn_corr_pkg holds:
  - default SAMP_WIDTH/ACC_WIDTH constants;
  - the FSM state typedef (WAIT_SOP, ACCUM);
  - the code-bit-to-sign helper;
  - saturation limit constants.
- One natural sub-module, prn_corr_acc_lane: sign flip, sign-extend, optional saturating add, clear/load/hold. Instantiated six times (I/Q x E/P/L).
- The top level holds the FSM, delay line, epoch counter and output register/handshake.

Test Plan:
- Reset mid-epoch: assert rx_rst during ACCUM -> all outputs 0 immediately, no vld until the next sop..eop after release.
- Matched code: I=+3, Q=0, code all 0, sop then 4092 valid samples ending in eop, rdy=1 -> tx_ip=12276, tx_qp=0, vld one cycle after eop, epoch_cnt=0.
- E/P/L alignment: EL_SPACING=2, I=+1, single code-1 chip at position 100 of a 4092-chip epoch -> tx_ie=tx_ip=tx_il=4090 (each tap sees the chip once within the epoch).
- Backpressure: rdy=0 across two epochs -> first result held unchanged, second dropped, tx_corr_ovf=1. With rdy=1, third result has epoch_cnt=2.
- Sop restart / enable drop: sop at sample 50 mid-epoch -> dump sums only samples 50..eop. rx_trk_en=0 for one cycle -> no dump until the next sop..eop.
- Overflow: ACC_WIDTH=8, I=+7, 40 samples -> wraps to 24 without CORR_SAT_EN, clamps to 127 with it.
